// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the two-stage core: owns the fetch PC and the EX PC,
// applies EX stalls, redirects and halt/resume, and counts retired and held cycles.
module fetch_ctrl #(
  parameter int PC_W     = 12,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_req,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] pc_fetch,
  output logic            imem_re,
  output logic [PC_W-1:0] pc_ex,
  output logic            ex_valid,
  output logic            flush_ex,
  output logic            halted,
  output logic [31:0]     instret,
  output logic [31:0]     stall_cycles
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]     RST_PC32 = RESET_PC;
  localparam logic [PC_W-1:0] PC_INIT  = RST_PC32[PC_W-1:0];

  state_t state;
  logic   running;
  logic   hold;
  logic   take;
  logic   stop;
  logic   retire;

  assign running = (state == RUN);
  assign hold    = running & ex_valid & stall_req;
  assign retire  = running & ex_valid & ~stall_req;
  assign take    = retire & redirect;
  assign stop    = retire & halt_req;

  // The wrong-path fetch is replaced by a NOP in the same edge that a branch or halt resolves.
  assign imem_re  = rst_n & running & ~hold;
  assign flush_ex = rst_n & (take | stop);
  assign halted   = (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      pc_fetch     <= PC_INIT;
      pc_ex        <= '0;
      ex_valid     <= 1'b0;
      instret      <= 32'd0;
      stall_cycles <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (hold) begin
            stall_cycles <= stall_cycles + 32'd1;
          end else begin
            if (retire)
              instret <= instret + 32'd1;
            if (stop) begin
              state    <= HALT;
              ex_valid <= 1'b0;
              pc_fetch <= take ? redirect_pc : pc_ex + PC_ONE;
            end else if (take) begin
              pc_fetch <= redirect_pc;
              ex_valid <= 1'b0;
            end else begin
              pc_ex    <= pc_fetch;
              pc_fetch <= pc_fetch + PC_ONE;
              ex_valid <= 1'b1;
            end
          end
        end
        HALT: begin
          if (resume)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: default instance plus a RESET_PC=4094 instance for wrap-around.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n, stall_req, redirect, halt_req, resume;
  logic [11:0] redirect_pc;
  logic [11:0] pc_fetch, pc_ex;
  logic        imem_re, ex_valid, flush_ex, halted;
  logic [31:0] instret, stall_cycles;

  logic        rst_n_w, halt_req_w, resume_w, stall_req_w, redirect_w;
  logic [11:0] redirect_pc_w;
  logic [11:0] pc_fetch_w, pc_ex_w;
  logic        imem_re_w, ex_valid_w, flush_ex_w, halted_w;
  logic [31:0] instret_w, stall_cycles_w;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.PC_W(12), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .resume(resume),
    .pc_fetch(pc_fetch), .imem_re(imem_re), .pc_ex(pc_ex), .ex_valid(ex_valid),
    .flush_ex(flush_ex), .halted(halted), .instret(instret), .stall_cycles(stall_cycles)
  );

  fetch_ctrl #(.PC_W(12), .RESET_PC(4094)) dut_w (
    .clk(clk), .rst_n(rst_n_w), .stall_req(stall_req_w), .redirect(redirect_w),
    .redirect_pc(redirect_pc_w), .halt_req(halt_req_w), .resume(resume_w),
    .pc_fetch(pc_fetch_w), .imem_re(imem_re_w), .pc_ex(pc_ex_w), .ex_valid(ex_valid_w),
    .flush_ex(flush_ex_w), .halted(halted_w), .instret(instret_w), .stall_cycles(stall_cycles_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the default instance's request inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic st, input logic rd, input logic [11:0] rpc,
                               input logic hr, input logic rs);
    stall_req   = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt_req    = hr;
    resume      = rs;
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    checkOutput("rst_imem_re", 32'(imem_re), 0);
    checkOutput("rst_flush_ex", 32'(flush_ex), 0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rst_n_w = 1'b0; halt_req_w = 1'b0; resume_w = 1'b0;
    stall_req_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = 12'd0;
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b0);

    // Reset state and free run
    resetDut();
    checkOutput("reset_pc_fetch", 32'(pc_fetch), 0);
    checkOutput("reset_pc_ex", 32'(pc_ex), 0);
    checkOutput("reset_ex_valid", 32'(ex_valid), 0);
    checkOutput("reset_halted", 32'(halted), 0);
    checkOutput("reset_instret", instret, 0);
    checkOutput("reset_stall", stall_cycles, 0);
    checkOutput("reset_imem_re", 32'(imem_re), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("run_pc_fetch", 32'(pc_fetch), 32'(k));
      checkOutput("run_pc_ex", 32'(pc_ex), 32'(k - 1));
      checkOutput("run_ex_valid", 32'(ex_valid), 1);
      checkOutput("run_instret", instret, 32'(k - 1));
    end

    // Stall three cycles at pc_ex=2
    resetDut();
    repeat (3) tick();
    checkOutput("pre_stall_pc_ex", 32'(pc_ex), 2);
    applyStimulus(1'b1, 1'b0, 12'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      checkOutput("stall_imem_re", 32'(imem_re), 0);
      tick();
      checkOutput("stall_pc_fetch", 32'(pc_fetch), 3);
      checkOutput("stall_pc_ex", 32'(pc_ex), 2);
      checkOutput("stall_instret", instret, 2);
      checkOutput("stall_count", stall_cycles, 32'(k));
    end
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b0);
    checkOutput("unstall_imem_re", 32'(imem_re), 1);
    tick();
    checkOutput("unstall_instret", instret, 3);
    checkOutput("unstall_pc_ex", 32'(pc_ex), 3);
    checkOutput("unstall_stall", stall_cycles, 3);

    // Redirect to 100 at pc_ex=4
    tick();
    checkOutput("pre_br_pc_ex", 32'(pc_ex), 4);
    applyStimulus(1'b0, 1'b1, 12'd100, 1'b0, 1'b0);
    checkOutput("br_flush", 32'(flush_ex), 1);
    tick();
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b0);
    checkOutput("br_ex_valid", 32'(ex_valid), 0);
    checkOutput("br_pc_fetch", 32'(pc_fetch), 100);
    checkOutput("br_pc_ex_hold", 32'(pc_ex), 4);
    checkOutput("br_flush_clr", 32'(flush_ex), 0);
    checkOutput("br_instret", instret, 5);
    tick();
    checkOutput("tgt_pc_ex", 32'(pc_ex), 100);
    checkOutput("tgt_ex_valid", 32'(ex_valid), 1);
    checkOutput("tgt_instret", instret, 5);

    // Halt at pc_ex=7, hold 10 cycles with noise, then resume
    resetDut();
    repeat (8) tick();
    checkOutput("pre_halt_pc_ex", 32'(pc_ex), 7);
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b1, 1'b0);
    checkOutput("halt_flush", 32'(flush_ex), 1);
    tick();
    applyStimulus(1'b1, 1'b1, 12'd33, 1'b1, 1'b0);
    checkOutput("halt_halted", 32'(halted), 1);
    checkOutput("halt_pc_fetch", 32'(pc_fetch), 8);
    checkOutput("halt_flush_off", 32'(flush_ex), 0);
    checkOutput("halt_instret", instret, 8);
    repeat (10) tick();
    checkOutput("halted_imem_re", 32'(imem_re), 0);
    checkOutput("halted_ex_valid", 32'(ex_valid), 0);
    checkOutput("halted_pc_fetch", 32'(pc_fetch), 8);
    checkOutput("halted_instret", instret, 8);
    checkOutput("halted_stall", stall_cycles, 0);
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b0);
    checkOutput("resume_halted", 32'(halted), 0);
    checkOutput("resume_imem_re", 32'(imem_re), 1);
    checkOutput("resume_pc_fetch", 32'(pc_fetch), 8);
    tick();
    checkOutput("resume_pc_ex", 32'(pc_ex), 8);
    checkOutput("resume_ex_valid", 32'(ex_valid), 1);
    checkOutput("resume_instret", instret, 8);

    // Halt together with stall, then resume, bubble redirect, redirect+halt to 50
    resetDut();
    repeat (3) tick();
    applyStimulus(1'b1, 1'b0, 12'd0, 1'b1, 1'b0);
    checkOutput("hs_flush", 32'(flush_ex), 0);
    repeat (2) tick();
    checkOutput("hs_halted", 32'(halted), 0);
    checkOutput("hs_stall", stall_cycles, 2);
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b1, 1'b0);
    checkOutput("hs_flush_rel", 32'(flush_ex), 1);
    tick();
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
    checkOutput("hs_halted_now", 32'(halted), 1);
    checkOutput("hs_pc_fetch", 32'(pc_fetch), 3);
    checkOutput("hs_instret", instret, 3);
    tick();
    applyStimulus(1'b0, 1'b1, 12'd77, 1'b0, 1'b0);
    checkOutput("bubble_flush", 32'(flush_ex), 0);
    tick();
    checkOutput("bubble_pc_fetch", 32'(pc_fetch), 4);
    checkOutput("bubble_pc_ex", 32'(pc_ex), 3);
    applyStimulus(1'b0, 1'b1, 12'd50, 1'b1, 1'b1);
    checkOutput("rh_flush", 32'(flush_ex), 1);
    tick();
    applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b0);
    checkOutput("rh_halted", 32'(halted), 1);
    checkOutput("rh_pc_fetch", 32'(pc_fetch), 50);
    checkOutput("rh_instret", instret, 4);

    // PC wrap with RESET_PC=4094, then reset during HALT
    rst_n_w = 1'b1;
    #1;
    checkOutput("w_reset_pc", 32'(pc_fetch_w), 4094);
    tick();
    checkOutput("w_pc_4095", 32'(pc_fetch_w), 4095);
    tick();
    checkOutput("w_pc_0", 32'(pc_fetch_w), 0);
    checkOutput("w_pc_ex", 32'(pc_ex_w), 4095);
    halt_req_w = 1'b1;
    tick();
    halt_req_w = 1'b0;
    checkOutput("w_halted", 32'(halted_w), 1);
    checkOutput("w_halt_pc", 32'(pc_fetch_w), 0);
    checkOutput("w_instret", instret_w, 2);
    rst_n_w = 1'b0;
    #1;
    checkOutput("w_rst_imem_re", 32'(imem_re_w), 0);
    tick();
    rst_n_w = 1'b1;
    #1;
    checkOutput("w_rst_halted", 32'(halted_w), 0);
    checkOutput("w_rst_pc", 32'(pc_fetch_w), 4094);
    checkOutput("w_rst_instret", instret_w, 0);
    checkOutput("w_rst_ex_valid", 32'(ex_valid_w), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the two-stage (FETCH -> EX/WB) CPU core.
- Owns the fetch PC and the PC of the instruction in EX.
- Handles EX-stage stalls, taken branches/jumps (squashing the wrong-path fetch), halt/resume, and retired-instruction and stall-cycle counters.
- Sits between the instruction RAM address/read port and the decoder/controller in the CPU top level.

Parameters:
- PC_W, 12, width of word-index PC (instruction RAM depth 2^PC_W).
- RESET_PC, 0, word address fetched first after reset.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset; synchronous, active-low.
- stall_req  input  1  EX instruction needs another cycle; hold pipeline (only meaningful when ex_valid=1).
- redirect  input  1  EX instruction is a taken branch/jump (only meaningful when ex_valid=1).
- redirect_pc  input  PC_W  word target of redirect.
- halt_req  input  1  EX instruction is a halt (ebreak).
- resume  input  1  single-cycle pulse; leave HALT.
- pc_fetch  output  PC_W  instruction RAM read address.
- imem_re  output  1  instruction RAM read enable; top loads instruction_EX only when high.
- pc_ex  output  PC_W  PC of instruction currently in EX.
- ex_valid  output  1  instruction in EX is architecturally valid; top gates regwrite/GPIO_we with it.
- flush_ex  output  1  combinational; top must load NOP (32'h00000013) into instruction_EX this edge.
- halted  output  1  state==HALT.
- instret  output  32  retired-instruction count.
- stall_cycles  output  32  count of held cycles.

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc_fetch=RESET_PC, pc_ex=0, ex_valid=0, state=RUN, instret=0, stall_cycles=0.
  - While rst_n=0: imem_re=0, flush_ex=0.
- States:
  - RUN=0: normal operation.
  - HALT=1: no fetch; ex_valid=0; only resume acts.
- Derived terms (RUN only):
  - hold = ex_valid & stall_req
  - take = ex_valid & ~stall_req & redirect
  - stop = ex_valid & ~stall_req & halt_req
  - retire = ex_valid & ~stall_req
- imem_re = (state==RUN) & ~hold.
- flush_ex = take | stop.
- Priority per RUN cycle: hold > (take and/or stop) > sequential.
- hold:
  - pc_fetch, pc_ex and ex_valid unchanged.
  - stall_cycles += 1.
  - redirect/halt_req ignored until stall_req drops.
- Sequential step:
  - pc_ex <= pc_fetch; pc_fetch <= pc_fetch+1.
  - ex_valid <= 1.
- take (without stop):
  - pc_fetch <= redirect_pc; ex_valid <= 0 (squash the fetch in flight).
  - Next cycle: pc_ex unchanged, fetch of target issued.
  - First target instruction reaches EX 2 cycles after the redirect cycle.
- stop:
  - state <= HALT; ex_valid <= 0.
  - pc_fetch <= take ? redirect_pc : pc_ex+1.
- retire: instret += 1. Covers branch and halt instructions and the final cycle of a stalled instruction.
- HALT:
  - imem_re=0, flush_ex=0, counters frozen.
  - stall_req, redirect, halt_req ignored.
  - resume: state <= RUN, pc/ex_valid unchanged; fetch of pc_fetch issued next cycle.
  - resume in RUN is ignored; resume and halt_req in the same RUN cycle: halt wins.
- Redirect/halt_req with ex_valid=0 (bubble): ignored; sequential step.
- Wrap-around:
  - pc_fetch+1 wraps modulo 2^PC_W (4095 -> 0 at default).
  - instret and stall_cycles wrap modulo 2^32.
- Reset mid-stall/mid-halt: reset wins, all state as above next cycle.
- All outputs except imem_re and flush_ex are registered.

Test Plan:
- Reset then free-run 5 cycles, no stimulus -> pc_fetch 0,1,2,3,4,5; ex_valid 0,1,1,1,1; pc_ex follows pc_fetch by one; instret=4 at cycle 5.
- stall_req high 3 cycles while pc_ex=2 -> pc_fetch holds 3, imem_re=0 for 3 cycles, stall_cycles=3, instret advances once when stall drops.
- redirect=1, redirect_pc=100 at pc_ex=4 -> flush_ex=1 that cycle; next cycle ex_valid=0, pc_fetch=100; following cycle pc_ex=100, ex_valid=1.
- halt_req at pc_ex=7 -> halted=1, pc_fetch=8, imem_re=0, counters frozen for 10 cycles; resume pulse -> RUN, next EX pc_ex=8.
- halt_req + stall_req together -> stays in RUN holding until stall_req drops, then halts; redirect+halt_req to 50 -> HALT with pc_fetch=50.
- RESET_PC=4094, free-run -> pc_fetch 4094,4095,0; assert rst_n=0 during HALT -> RUN, pc_fetch=4094, counters 0.
